// File: rtl/flex_counter_ud_if.sv
// Control and status bundle for the up/down flex counter.
// master drives the controls, slave is the counter itself.
interface flex_counter_ud_if #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int WRAP_CNT_BITS = 8
);
    logic                     clear;
    logic                     load;
    logic [NUM_CNT_BITS-1:0]  load_val;
    logic                     count_enable;
    logic                     count_up;
    logic                     one_shot;
    logic [NUM_CNT_BITS-1:0]  rollover_val;
    logic [NUM_CNT_BITS-1:0]  count_out;
    logic                     rollover_flag;
    logic                     done;
    logic [WRAP_CNT_BITS-1:0] wrap_count;

    modport master (
        output clear, load, load_val, count_enable,
        output count_up, one_shot, rollover_val,
        input  count_out, rollover_flag, done, wrap_count
    );

    modport slave (
        input  clear, load, load_val, count_enable,
        input  count_up, one_shot, rollover_val,
        output count_out, rollover_flag, done, wrap_count
    );
endinterface

// File: rtl/flex_counter_ud.sv
// Up/down flex counter with load, one-shot halt and registered flags.
// Define FLEX_COUNTER_WRAP_STATS_EN to build the saturating wrap counter.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int WRAP_CNT_BITS = 8
) (
    input logic               clk,
    input logic               n_rst,
    flex_counter_ud_if.slave  bus
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [NUM_CNT_BITS-1:0] cnt;
    logic                    flag;
    logic                    done_q;
    logic [NUM_CNT_BITS-1:0] step_val;
    logic [NUM_CNT_BITS-1:0] term;
    logic                    rv_zero;
    logic                    hit_term;
    logic                    load_term;

    // Next step value and terminal-value tests for the current direction
    always_comb begin
        rv_zero   = (bus.rollover_val == '0);
        term      = bus.count_up ? bus.rollover_val : ONE;
        step_val  = '0;
        if (rv_zero) begin
            step_val = '0;
        end else if (bus.count_up) begin
            step_val = (cnt >= bus.rollover_val) ? ONE : cnt + ONE;
        end else begin
            step_val = (cnt <= ONE || cnt > bus.rollover_val) ?
                       bus.rollover_val : cnt - ONE;
        end
        hit_term  = !rv_zero && (step_val == term);
        load_term = !rv_zero && (bus.load_val == term);
    end

    // Count register, flags and control FSM (clear > load > step)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt    <= '0;
            flag   <= 1'b0;
            done_q <= 1'b0;
            state  <= IDLE;
        end else if (bus.clear) begin
            cnt    <= '0;
            flag   <= 1'b0;
            done_q <= 1'b0;
            state  <= IDLE;
        end else if (bus.load) begin
            cnt    <= bus.load_val;
            flag   <= load_term;
            done_q <= 1'b0;
            state  <= RUN;
        end else if (bus.count_enable && state != DONE) begin
            cnt  <= step_val;
            flag <= hit_term;
            if (bus.one_shot && hit_term) begin
                state  <= DONE;
                done_q <= 1'b1;
            end else begin
                state  <= RUN;
            end
        end
    end

    assign bus.count_out     = cnt;
    assign bus.rollover_flag = flag;
    assign bus.done          = done_q;

`ifdef FLEX_COUNTER_WRAP_STATS_EN
    logic                     wrap_evt;
    logic [WRAP_CNT_BITS-1:0] wraps;

    // A wrap is an enabled step leaving the terminal value while running
    assign wrap_evt = bus.count_enable && !bus.clear && !bus.load &&
                      state == RUN && !rv_zero && cnt == term;

    // Saturating wrap-event counter, cleared only by reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wraps <= '0;
        end else if (wrap_evt && wraps != '1) begin
            wraps <= wraps + WRAP_CNT_BITS'(1);
        end
    end

    assign bus.wrap_count = wraps;
`else
    assign bus.wrap_count = {WRAP_CNT_BITS{1'b0}};
`endif
endmodule

// File: tb/tb_flex_counter_ud.sv
// Directed testbench for flex_counter_ud.
// Expected values are hand-computed per scenario.
module tb_flex_counter_ud;
    logic tb_clk;
    logic n_rst;
    int   n_checks;
    int   n_fail;

    flex_counter_ud_if #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(8)) bus ();

    flex_counter_ud #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(8)) dut (
        .clk   (tb_clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear        = 1'b0;
        bus.load         = 1'b0;
        bus.load_val     = 4'd0;
        bus.count_enable = 1'b0;
        bus.count_up     = 1'b1;
        bus.one_shot     = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        tick();
        bus.load     = 1'b0;
    endtask

    initial begin
        int exp_c;
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        bus.rollover_val = 4'd10;
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        tick();

        // reset state
        check("rst_count", bus.count_out, 0);
        check("rst_flag", bus.rollover_flag, 0);
        check("rst_done", bus.done, 0);
        check("rst_wrap", bus.wrap_count, 0);

        // async reset mid-count
        bus.count_enable = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_count", bus.count_out, 7);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_count", bus.count_out, 0);
        check("async_flag", bus.rollover_flag, 0);
        check("async_done", bus.done, 0);
        bus.count_enable = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        check("post_rst_count", bus.count_out, 0);
        check("post_rst_done", bus.done, 0);

        // up wrap
        bus.rollover_val = 4'd10;
        bus.count_up     = 1'b1;
        bus.one_shot     = 1'b0;
        bus.count_enable = 1'b1;
        for (int i = 0; i < 21; i++) begin
            tick();
            exp_c = (i % 10) + 1;
            check($sformatf("up_cnt%0d", i), bus.count_out, exp_c);
            check($sformatf("up_flag%0d", i), bus.rollover_flag,
                  (exp_c == 10) ? 1 : 0);
        end
        bus.count_enable = 1'b0;
`ifdef FLEX_COUNTER_WRAP_STATS_EN
        check("up_wraps", bus.wrap_count, 2);
`else
        check("up_wraps", bus.wrap_count, 0);
`endif

        // down wrap
        do_clear();
        check("dn_clr", bus.count_out, 0);
        bus.rollover_val = 4'd5;
        bus.count_up     = 1'b0;
        bus.count_enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_c = 5 - (i % 5);
            check($sformatf("dn_cnt%0d", i), bus.count_out, exp_c);
            check($sformatf("dn_flag%0d", i), bus.rollover_flag,
                  (exp_c == 1) ? 1 : 0);
        end
        bus.count_enable = 1'b0;

        // one-shot
        do_clear();
        bus.rollover_val = 4'd6;
        bus.count_up     = 1'b1;
        bus.one_shot     = 1'b1;
        bus.count_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_c = (i + 1 > 6) ? 6 : i + 1;
            check($sformatf("os_cnt%0d", i), bus.count_out, exp_c);
            check($sformatf("os_done%0d", i), bus.done,
                  (i >= 5) ? 1 : 0);
            check($sformatf("os_flag%0d", i), bus.rollover_flag,
                  (exp_c == 6) ? 1 : 0);
        end
        bus.one_shot = 1'b0;
        bus.count_enable = 1'b1;
        tick();
        check("os_hold_cnt", bus.count_out, 6);
        check("os_hold_done", bus.done, 1);
        bus.count_enable = 1'b0;
        bus.one_shot = 1'b1;
        do_load(4'd2);
        check("os_load_cnt", bus.count_out, 2);
        check("os_load_done", bus.done, 0);
        check("os_load_flag", bus.rollover_flag, 0);
        bus.count_enable = 1'b1;
        tick();
        bus.count_enable = 1'b0;
        bus.one_shot = 1'b0;
        check("os_resume", bus.count_out, 3);

        // priority
        bus.rollover_val = 4'd10;
        do_load(4'd4);
        check("pri_pre", bus.count_out, 4);
        bus.clear        = 1'b1;
        bus.load         = 1'b1;
        bus.load_val     = 4'd7;
        bus.count_enable = 1'b1;
        tick();
        bus.clear        = 1'b0;
        bus.load         = 1'b0;
        bus.count_enable = 1'b0;
        check("pri_clr_cnt", bus.count_out, 0);
        check("pri_clr_flag", bus.rollover_flag, 0);
        check("pri_clr_done", bus.done, 0);
        bus.load         = 1'b1;
        bus.load_val     = 4'd9;
        bus.count_enable = 1'b1;
        tick();
        bus.load         = 1'b0;
        bus.count_enable = 1'b0;
        check("pri_load", bus.count_out, 9);
        check("pri_load_flag", bus.rollover_flag, 0);
        do_load(4'd10);
        check("load_term_flag", bus.rollover_flag, 1);

        // bound change, up then down
        bus.count_up = 1'b1;
        do_load(4'd8);
        bus.rollover_val = 4'd5;
        bus.count_enable = 1'b1;
        tick();
        bus.count_enable = 1'b0;
        check("bnd_up", bus.count_out, 1);
        bus.rollover_val = 4'd10;
        bus.count_up = 1'b0;
        do_load(4'd8);
        bus.rollover_val = 4'd5;
        bus.count_enable = 1'b1;
        tick();
        bus.count_enable = 1'b0;
        check("bnd_dn", bus.count_out, 5);
        check("bnd_dn_flag", bus.rollover_flag, 0);

        // direction change mid-count
        bus.count_enable = 1'b1;
        tick();
        check("dir_dn", bus.count_out, 4);
        bus.count_up = 1'b1;
        tick();
        check("dir_up", bus.count_out, 5);
        check("dir_up_flag", bus.rollover_flag, 1);
        bus.count_enable = 1'b0;

        // rollover_val = 0 and 1
        bus.rollover_val = 4'd0;
        bus.count_enable = 1'b1;
        tick();
        check("rv0_cnt", bus.count_out, 0);
        check("rv0_flag", bus.rollover_flag, 0);
        bus.rollover_val = 4'd1;
        tick();
        tick();
        check("rv1_cnt", bus.count_out, 1);
        check("rv1_flag", bus.rollover_flag, 1);
        bus.count_up = 1'b0;
        tick();
        check("rv1_dn_cnt", bus.count_out, 1);
        check("rv1_dn_flag", bus.rollover_flag, 1);
        bus.count_enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
